// File: rtl/rob_pkg.sv
// Shared widths and types for the o3cpu reorder buffer, so RS, FUs and the rename table agree.
package rob_pkg;

  localparam int unsigned ROB_ENTRY_WIDTH = 3;
  localparam int unsigned REG_ADDR_WIDTH  = 5;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned ROB_DEPTH       = 2 ** ROB_ENTRY_WIDTH;

  typedef logic [ROB_ENTRY_WIDTH-1:0] tag_t;
  // Head/tail pointers carry one extra wrap bit to tell full from empty.
  typedef logic [ROB_ENTRY_WIDTH:0]   ptr_t;
  typedef logic [REG_ADDR_WIDTH-1:0]  reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]      data_t;

  typedef struct packed {
    logic      busy;
    logic      done;
    logic      reg_we;
    reg_addr_t dest_reg;
    data_t     value;
  } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Issue/lookup/CDB/commit bundle of the reorder buffer; master is the core side, slave the ROB.
interface rob_if;
  import rob_pkg::*;

  logic      alloc_valid;
  logic      alloc_reg_we;
  reg_addr_t alloc_dest_reg;
  logic      alloc_ready;
  tag_t      alloc_tag;

  tag_t      qj_tag;
  tag_t      qk_tag;
  logic      qj_ready;
  logic      qk_ready;
  data_t     qj_value;
  data_t     qk_value;

  logic      cdb_valid;
  tag_t      cdb_tag;
  data_t     cdb_value;

  logic      commit_valid;
  logic      commit_reg_we;
  reg_addr_t commit_dest_reg;
  data_t     commit_value;
  tag_t      commit_tag;

  logic      flush;
  logic      full;
  logic      empty;
  ptr_t      count;

  modport master (
    output alloc_valid, alloc_reg_we, alloc_dest_reg, qj_tag, qk_tag,
    output cdb_valid, cdb_tag, cdb_value, flush,
    input  alloc_ready, alloc_tag, qj_ready, qk_ready, qj_value, qk_value,
    input  commit_valid, commit_reg_we, commit_dest_reg, commit_value, commit_tag,
    input  full, empty, count
  );

  modport slave (
    input  alloc_valid, alloc_reg_we, alloc_dest_reg, qj_tag, qk_tag,
    input  cdb_valid, cdb_tag, cdb_value, flush,
    output alloc_ready, alloc_tag, qj_ready, qk_ready, qj_value, qk_value,
    output commit_valid, commit_reg_we, commit_dest_reg, commit_value, commit_tag,
    output full, empty, count
  );

endinterface

// File: rtl/rob.sv
// Reorder buffer: allocates tags in program order, captures CDB results, retires in order.
module rob
  import rob_pkg::*;
(
  input logic clk,
  input logic rst,
  rob_if.slave rob_io
);

  rob_entry_t entry_q [ROB_DEPTH];
  rob_entry_t entry_d [ROB_DEPTH];
  ptr_t       head_q, head_d;
  ptr_t       tail_q, tail_d;

  tag_t head_idx, tail_idx;
  logic full, empty, commit_valid, alloc_fire, qj_hit, qk_hit;

  assign head_idx     = head_q[ROB_ENTRY_WIDTH-1:0];
  assign tail_idx     = tail_q[ROB_ENTRY_WIDTH-1:0];
  assign empty        = (head_q == tail_q);
  assign full         = (head_idx == tail_idx) &&
                        (head_q[ROB_ENTRY_WIDTH] != tail_q[ROB_ENTRY_WIDTH]);
  assign commit_valid = entry_q[head_idx].busy && entry_q[head_idx].done;
  assign alloc_fire   = rob_io.alloc_valid && !full;

  assign rob_io.alloc_ready = !full;
  assign rob_io.alloc_tag   = tail_idx;
  assign rob_io.full        = full;
  assign rob_io.empty       = empty;
  assign rob_io.count       = tail_q - head_q;

  // Commit fields are zeroed when nothing retires so stale entries never leak out.
  assign rob_io.commit_valid    = commit_valid;
  assign rob_io.commit_reg_we   = commit_valid && entry_q[head_idx].reg_we;
  assign rob_io.commit_dest_reg = commit_valid ? entry_q[head_idx].dest_reg : '0;
  assign rob_io.commit_value    = commit_valid ? entry_q[head_idx].value : '0;
  assign rob_io.commit_tag      = commit_valid ? head_idx : '0;

  // Lookup sees registered state only; same-cycle CDB is snooped by the RS itself.
  assign qj_hit          = entry_q[rob_io.qj_tag].busy && entry_q[rob_io.qj_tag].done;
  assign qk_hit          = entry_q[rob_io.qk_tag].busy && entry_q[rob_io.qk_tag].done;
  assign rob_io.qj_ready = qj_hit;
  assign rob_io.qk_ready = qk_hit;
  assign rob_io.qj_value = qj_hit ? entry_q[rob_io.qj_tag].value : '0;
  assign rob_io.qk_value = qk_hit ? entry_q[rob_io.qk_tag].value : '0;

  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (rob_io.flush) begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        entry_d[i].busy = 1'b0;
        entry_d[i].done = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      if (rob_io.cdb_valid && entry_q[rob_io.cdb_tag].busy) begin
        entry_d[rob_io.cdb_tag].value = rob_io.cdb_value;
        entry_d[rob_io.cdb_tag].done  = 1'b1;
      end
      if (commit_valid) begin
        entry_d[head_idx].busy = 1'b0;
        entry_d[head_idx].done = 1'b0;
        head_d = head_q + ptr_t'(1);
      end
      // Head and tail slots coincide only when empty or full, where one side is idle.
      if (alloc_fire) begin
        entry_d[tail_idx].busy     = 1'b1;
        entry_d[tail_idx].done     = 1'b0;
        entry_d[tail_idx].reg_we   = rob_io.alloc_reg_we;
        entry_d[tail_idx].dest_reg = rob_io.alloc_dest_reg;
        entry_d[tail_idx].value    = '0;
        tail_d = tail_q + ptr_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        entry_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a queue-based scoreboard of allocated entries predicts every output.
module tb_rob;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_if u_if ();

  rob u_dut (
    .clk    (clk),
    .rst    (rst_n),
    .rob_io (u_if.slave)
  );

  typedef struct packed {
    tag_t      tag;
    logic      we;
    reg_addr_t dst;
  } sb_t;

  sb_t   sb_q [$];
  logic  mbusy [ROB_DEPTH];
  logic  mdone [ROB_DEPTH];
  data_t mval  [ROB_DEPTH];
  int    mtail;
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(ROB_DEPTH); i++) begin
      mbusy[i] = 1'b0;
      mdone[i] = 1'b0;
      mval[i]  = '0;
    end
    sb_q.delete();
    mtail = 0;
  endtask

  // Compare every output against the scoreboard; commit fields checked against queue front.
  task automatic check_state();
    int   sz;
    logic exp_cv;
    tag_t h;
    logic jr, kr;
    sz = sb_q.size();
    exp_cv = 1'b0;
    h = '0;
    if (sz > 0) begin
      h = sb_q[0].tag;
      exp_cv = mdone[h];
    end
    check("count", 32'(u_if.count), 32'(sz));
    check("full", 32'(u_if.full), 32'(sz == int'(ROB_DEPTH)));
    check("empty", 32'(u_if.empty), 32'(sz == 0));
    check("alloc_ready", 32'(u_if.alloc_ready), 32'(sz != int'(ROB_DEPTH)));
    check("alloc_tag", 32'(u_if.alloc_tag), 32'(mtail));
    check("commit_valid", 32'(u_if.commit_valid), 32'(exp_cv));
    if (exp_cv) begin
      check("commit_tag", 32'(u_if.commit_tag), 32'(h));
      check("commit_value", u_if.commit_value, mval[h]);
      check("commit_dest_reg", 32'(u_if.commit_dest_reg), 32'(sb_q[0].dst));
      check("commit_reg_we", 32'(u_if.commit_reg_we), 32'(sb_q[0].we));
    end else begin
      check("commit_reg_we_idle", 32'(u_if.commit_reg_we), 32'(0));
    end
    jr = mbusy[u_if.qj_tag] && mdone[u_if.qj_tag];
    kr = mbusy[u_if.qk_tag] && mdone[u_if.qk_tag];
    check("qj_ready", 32'(u_if.qj_ready), 32'(jr));
    check("qk_ready", 32'(u_if.qk_ready), 32'(kr));
    check("qj_value", u_if.qj_value, jr ? mval[u_if.qj_tag] : 32'h0);
    check("qk_value", u_if.qk_value, kr ? mval[u_if.qk_tag] : 32'h0);
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance the model, step past the edge.
  task automatic tick(input logic av, input logic we, input reg_addr_t dst, input logic cv,
                      input tag_t ctag, input data_t cval, input logic fl);
    int   sz0;
    logic cv0;
    u_if.alloc_valid    = av;
    u_if.alloc_reg_we   = we;
    u_if.alloc_dest_reg = dst;
    u_if.cdb_valid      = cv;
    u_if.cdb_tag        = ctag;
    u_if.cdb_value      = cval;
    u_if.flush          = fl;
    #1;
    check_state();
    sz0 = sb_q.size();
    cv0 = (sz0 > 0) && mdone[sb_q[0].tag];
    if (fl) begin
      model_clear();
    end else begin
      if (cv && mbusy[ctag]) begin
        mval[ctag]  = cval;
        mdone[ctag] = 1'b1;
      end
      if (cv0) begin
        mbusy[sb_q[0].tag] = 1'b0;
        mdone[sb_q[0].tag] = 1'b0;
        void'(sb_q.pop_front());
      end
      if (av && sz0 < int'(ROB_DEPTH)) begin
        mbusy[mtail] = 1'b1;
        mdone[mtail] = 1'b0;
        mval[mtail]  = '0;
        sb_q.push_back('{tag: tag_t'(mtail), we: we, dst: dst});
        mtail = (mtail + 1) % int'(ROB_DEPTH);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tag_t prev, cur, base;
    logic have_prev;

    u_if.alloc_valid = 1'b0;  u_if.alloc_reg_we = 1'b0;  u_if.alloc_dest_reg = '0;
    u_if.qj_tag = '0;         u_if.qk_tag = '0;
    u_if.cdb_valid = 1'b0;    u_if.cdb_tag = '0;         u_if.cdb_value = '0;
    u_if.flush = 1'b0;
    model_clear();

    // Reset hold
    #12;
    check("rst_empty", 32'(u_if.empty), 32'(1));
    check("rst_full", 32'(u_if.full), 32'(0));
    check("rst_alloc_ready", 32'(u_if.alloc_ready), 32'(1));
    check("rst_count", 32'(u_if.count), 32'(0));
    check("rst_alloc_tag", 32'(u_if.alloc_tag), 32'(0));
    check("rst_commit_valid", 32'(u_if.commit_valid), 32'(0));
    check("rst_commit_value", u_if.commit_value, 32'h0);
    check("rst_commit_tag", 32'(u_if.commit_tag), 32'(0));
    check("rst_commit_dest", 32'(u_if.commit_dest_reg), 32'(0));
    check("rst_qj_ready", 32'(u_if.qj_ready), 32'(0));
    check("rst_qk_value", u_if.qk_value, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full, then a rejected 9th alloc
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, reg_addr_t'(i + 1), 1'b0, '0, '0, 1'b0);
    check("fill_full", 32'(u_if.full), 32'(1));
    check("fill_alloc_ready", 32'(u_if.alloc_ready), 32'(0));
    check("fill_count", 32'(u_if.count), 32'(8));
    tick(1'b1, 1'b1, 5'd30, 1'b0, '0, '0, 1'b0);
    check("ninth_count", 32'(u_if.count), 32'(8));

    // Full with commit and alloc in the same cycle: alloc rejected, count drops to 7
    tick(1'b0, 1'b0, '0, 1'b1, 3'd0, 32'hA0, 1'b0);
    tick(1'b1, 1'b1, 5'd20, 1'b0, '0, '0, 1'b0);
    check("full_commit_count", 32'(u_if.count), 32'(7));
    check("full_commit_full", 32'(u_if.full), 32'(0));
    tick(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
    check("flush1_empty", 32'(u_if.empty), 32'(1));

    // Out-of-order completion, in-order retirement
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, reg_addr_t'(i + 1), 1'b0, '0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 3'd2, 32'h22, 1'b0);
    check("order_no_early", 32'(u_if.commit_valid), 32'(0));
    tick(1'b0, 1'b0, '0, 1'b1, 3'd0, 32'h10, 1'b0);
    check("order_c0_tag", 32'(u_if.commit_tag), 32'(0));
    check("order_c0_val", u_if.commit_value, 32'h10);
    tick(1'b0, 1'b0, '0, 1'b1, 3'd1, 32'h11, 1'b0);
    check("order_c1_tag", 32'(u_if.commit_tag), 32'(1));
    check("order_c1_val", u_if.commit_value, 32'h11);
    idle();
    check("order_c2_tag", 32'(u_if.commit_tag), 32'(2));
    check("order_c2_val", u_if.commit_value, 32'h22);
    idle();

    // Lookup: tag3 done, tag4 busy but pending
    tick(1'b1, 1'b1, 5'd7, 1'b0, '0, '0, 1'b0);
    tick(1'b1, 1'b0, 5'd8, 1'b1, 3'd3, 32'hABCD, 1'b0);
    u_if.qj_tag = 3'd3;
    u_if.qk_tag = 3'd4;
    #1;
    check("lookup_qj_ready", 32'(u_if.qj_ready), 32'(1));
    check("lookup_qj_value", u_if.qj_value, 32'hABCD);
    check("lookup_qk_ready", 32'(u_if.qk_ready), 32'(0));
    check("lookup_qk_value", u_if.qk_value, 32'h0);
    tick(1'b0, 1'b0, '0, 1'b1, 3'd4, 32'h44, 1'b0);
    idle();
    idle();

    // CDB to non-busy tag 5 is ignored
    u_if.qj_tag = 3'd5;
    tick(1'b0, 1'b0, '0, 1'b1, 3'd5, 32'h55, 1'b0);
    check("nb_empty", 32'(u_if.empty), 32'(1));
    check("nb_qj_ready", 32'(u_if.qj_ready), 32'(0));
    check("nb_qj_value", u_if.qj_value, 32'h0);
    check("nb_commit", 32'(u_if.commit_valid), 32'(0));

    // Wrap: streaming alloc/CDB/commit across several tag wraps
    have_prev = 1'b0;
    prev = '0;
    for (int k = 0; k < 20; k++) begin
      cur = tag_t'(mtail);
      u_if.qk_tag = prev;
      tick(1'b1, k[0], reg_addr_t'(k), have_prev, prev, $urandom, 1'b0);
      check("wrap_not_full", 32'(u_if.full), 32'(0));
      prev = cur;
      have_prev = 1'b1;
    end
    tick(1'b0, 1'b0, '0, 1'b1, prev, 32'h5A5A, 1'b0);
    idle();
    idle();

    // Flush with 5 in flight plus same-cycle alloc and CDB
    base = tag_t'(mtail);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, reg_addr_t'(i + 9), 1'b0, '0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, base + 3'd2, 32'h77, 1'b0);
    tick(1'b1, 1'b1, 5'd3, 1'b1, base, 32'h99, 1'b1);
    check("flush_empty", 32'(u_if.empty), 32'(1));
    check("flush_count", 32'(u_if.count), 32'(0));
    check("flush_alloc_tag", 32'(u_if.alloc_tag), 32'(0));
    check("flush_no_commit", 32'(u_if.commit_valid), 32'(0));
    idle();

    // Reset mid-operation with a commit pending
    tick(1'b1, 1'b1, 5'd4, 1'b0, '0, '0, 1'b0);
    tick(1'b1, 1'b1, 5'd5, 1'b1, 3'd0, 32'h1234, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_commit", 32'(u_if.commit_valid), 32'(0));
    check("midrst_empty", 32'(u_if.empty), 32'(1));
    check("midrst_count", 32'(u_if.count), 32'(0));
    model_clear();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1, 1'b1, 5'd6, 1'b0, '0, '0, 1'b0);
    tick(1'b0, 1'b0, '0, 1'b1, 3'd0, 32'hBEEF, 1'b0);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
